// File: rtl/result_fifo.sv
// Result FIFO: buffers ALU result words for a downstream consumer, first-word fall-through.
// Latency: a word pushed at edge N is on data_out with valido=1 right after edge N.
// Backpressure: ready_in stalls the head; writes while full are dropped and latch overflow.
//
// Ports:
//   Clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   validi    - data_in carries a result word to store
//   data_in   - result word (WIDTH bits)
//   ready_in  - consumer accepts the head word this cycle
//   valido    - data_out holds a valid head word
//   data_out  - oldest stored word, zero when nothing is stored
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - number of stored words
//   overflow  - sticky: a write arrived while full and was dropped
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     validi,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     ready_in,
    output logic                     valido,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    // Flags come straight from the registered count so they never glitch on inputs.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign valido = ~empty;

    // Full blocks a write even if the head leaves on the same edge; empty blocks a pop.
    assign push = validi & ~full;
    assign pop  = valido & ready_in;

    // Masking with valido keeps stale array contents off the output after reset.
    assign data_out = valido ? mem[rd_ptr] : '0;

    // Storage carries no reset; only entries between the pointers are ever visible.
    always_ff @(posedge Clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // DEPTH is a power of two, so natural pointer rollover gives modulo-DEPTH wrap.
    always_ff @(posedge Clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (validi && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_fifo.sv
// Testbench for result_fifo: scoreboard queue of expected words, full state checked every cycle.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 unit after the next.
// Backpressure: the model mirrors push/pop acceptance from its own occupancy, not from the DUT.
module tb_result_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             Clk = 1'b0;
    logic             rst;
    logic             validi;
    logic [WIDTH-1:0] data_in;
    logic             ready_in;
    logic             valido;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf;

    result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .rst      (rst),
        .validi   (validi),
        .data_in  (data_in),
        .ready_in (ready_in),
        .valido   (valido),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = exp_q.size();
        chk({tag, ":count"},    32'(count),    32'(sz));
        chk({tag, ":empty"},    32'(empty),    32'(sz == 0));
        chk({tag, ":full"},     32'(full),     32'(sz == DEPTH));
        chk({tag, ":valido"},   32'(valido),   32'(sz != 0));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ":data_out"}, 32'(data_out), (sz != 0) ? 32'(exp_q[0]) : 32'h0);
    endtask

    // One clock: drive inputs, predict acceptance from model occupancy, check after the edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
        bit m_full;
        bit m_empty;
        bit do_push;
        bit do_pop;
        validi   = v;
        data_in  = d;
        ready_in = r;
        m_full   = (exp_q.size() == DEPTH);
        m_empty  = (exp_q.size() == 0);
        do_push  = v && !m_full;
        do_pop   = r && !m_empty;
        if (v && m_full) m_ovf = 1'b1;
        @(posedge Clk);
        #1;
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        check_state(tag);
    endtask

    // Reset edge with arbitrary inputs present; those inputs must be discarded.
    task automatic do_reset(input logic v, input logic [WIDTH-1:0] d, input logic r);
        rst      = 1'b1;
        validi   = v;
        data_in  = d;
        ready_in = r;
        @(posedge Clk);
        #1;
        exp_q.delete();
        m_ovf    = 1'b0;
        rst      = 1'b0;
        validi   = 1'b0;
        ready_in = 1'b0;
        check_state("reset");
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, tag);
    endtask

    initial begin
        rst      = 1'b1;
        validi   = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        m_ovf    = 1'b0;
        @(posedge Clk);
        #1;
        do_reset(1'b0, 8'h00, 1'b0);

        // Single push into empty FIFO appears one cycle later.
        cycle(1'b1, 8'h11, 1'b0, "push_one");
        drain("push_one_drain");

        // Fill to full, drop an extra write, drain in order.
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
        cycle(1'b1, 8'hFF, 1'b0, "ovf_push");
        drain("fill_drain");

        // Write while full with a simultaneous pop: pop happens, write dropped.
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, "fill2");
        cycle(1'b1, 8'hEE, 1'b1, "full_pushpop");
        drain("full_pushpop_drain");

        // Continuous streaming: occupancy stays 1, pointers wrap more than twice.
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b1, "stream");
        drain("stream_drain");

        // ready_in on empty FIFO is ignored; a later word must come out first.
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, "empty_rdy");
        cycle(1'b1, 8'h5A, 1'b0, "after_empty");
        drain("after_empty_drain");

        // Mid-operation reset with a pending write discards everything.
        cycle(1'b1, 8'hA1, 1'b0, "pre_rst");
        cycle(1'b1, 8'hA2, 1'b0, "pre_rst");
        cycle(1'b1, 8'hA3, 1'b0, "pre_rst");
        cycle(1'b1, 8'hFF, 1'b0, "pre_rst");
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hF0, 1'b0, "pre_rst_ovf");
        do_reset(1'b1, 8'hA4, 1'b1);
        cycle(1'b1, 8'hB0, 1'b0, "post_rst");
        drain("post_rst_drain");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), 8'($urandom),
                  1'($urandom_range(0, 99) < 45), "random");
        end
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of storage entries and SHALL be a power of two, 2 or greater.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of Clk.
REQ-005 validi  input  1  SHALL qualify data_in as a result word from the upstream ALU stage.
REQ-006 data_in  input  WIDTH  SHALL be the result word to store.
REQ-007 ready_in  input  1  SHALL be the downstream consumer's acceptance of the head word.
REQ-008 valido  output  1  SHALL indicate that data_out holds a valid head word.
REQ-009 data_out  output  WIDTH  SHALL be the oldest stored word, first-word fall-through.
REQ-010 full  output  1  SHALL be high when count equals DEPTH.
REQ-011 empty  output  1  SHALL be high when count equals 0.
REQ-012 count  output  clog2(DEPTH)+1  SHALL be the number of stored words.
REQ-013 overflow  output  1  SHALL be a sticky flag for a dropped write.

Function
REQ-014 A push SHALL occur on a rising edge when validi=1 and full=0; data_in is written at the write pointer, which advances by 1.
REQ-015 A pop SHALL occur on a rising edge when valido=1 and ready_in=1; the read pointer advances by 1.
REQ-016 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0) with no skipped or duplicated entry.
REQ-017 valido SHALL equal not empty; data_out SHALL equal the entry at the read pointer when valido=1 and all zeros when valido=0.
REQ-018 Push latency SHALL be one cycle: a word pushed into an empty FIFO at edge N appears on data_out with valido=1 after edge N.
REQ-019 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and preserve word order.
REQ-020 When full=1, validi=1 SHALL drop the word and set overflow on that edge, even if a pop occurs on the same edge.
REQ-021 When empty=1, ready_in SHALL be ignored; count, pointers, and data SHALL remain unchanged, and no underflow is possible.
REQ-022 count SHALL update as +1 on push only, -1 on pop only, and 0 on both or neither; full and empty SHALL be derived combinationally from the registered count.
REQ-023 overflow SHALL stay high once set until rst.
REQ-024 ready_in SHALL NOT gate pushes, and validi SHALL NOT gate pops.

Reset
REQ-025 When rst=1 on a rising edge, read pointer, write pointer, and count SHALL become 0 and overflow SHALL become 0, giving valido=0, data_out=0, empty=1, full=0.
REQ-026 rst SHALL take priority over a simultaneous push or pop, and the inputs on that edge SHALL be discarded.
REQ-027 Storage array contents SHALL NOT require reset; after reset, stale entries SHALL never appear on data_out.
REQ-028 rst asserted mid-operation (partially full) SHALL discard all stored words; the next push after reset SHALL be the next word output.

Verification
REQ-029 Reset, then push 8'h11 with ready_in=0 -> one cycle later valido=1, data_out=8'h11, count=1, empty=0.
REQ-030 Push 8'h01..8'h08 with ready_in=0, then attempt push 8'hFF -> full=1, count=8, overflow=1, and a drain with ready_in=1 yields 8'h01..8'h08 in order with no 8'hFF.
REQ-031 Hold validi=1 and ready_in=1 continuously with an incrementing stream from 8'h00 for 20 cycles -> count stays 1 after the first word, output is in order with no loss, and the pointers wrap at least twice.
REQ-032 Empty FIFO with ready_in=1 and validi=0 for 5 cycles -> valido=0, data_out=8'h00, count=0, with no pointer movement.
REQ-033 Push 8'hA1, 8'hA2, 8'hA3, assert rst with validi=1 and data_in=8'hA4, then push 8'hB0 -> after reset count=0 and overflow=0, and the next output is 8'hB0.
REQ-034 At full=1, apply validi=1 with data 8'hEE and ready_in=1 simultaneously -> count=7, head advances, 8'hEE is dropped, and overflow=1.
